// File: rtl/hazard_stall_ctrl.sv
// Fixed-priority decode stall controller: accepts one hazard channel, stalls for its
// requested length, masks requests for one release cycle, and keeps saturating stall statistics.
module hazard_stall_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32,
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       hazard_req,
    input  logic [NUM_SRC*CNT_W-1:0] hazard_len,
    input  logic                     flush,
    input  logic                     stat_clear,
    output logic                     stall,
    output logic [SRC_W-1:0]         stall_src,
    output logic [CNT_W-1:0]         stall_remaining,
    output logic [STAT_W-1:0]        stat_stall_cycles,
    output logic [STAT_W-1:0]        stat_hazard_events
);

    // state     | meaning
    // S_IDLE    | no episode; an eligible request is accepted and stalls this cycle
    // S_STALL   | stalling for a latched channel; requests ignored
    // S_RELEASE | one cycle with stall low and all requests masked
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STALL   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0]   event_cnt_q, event_cnt_d;

    logic                any_elig;
    logic [SRC_W-1:0]    sel_idx;
    logic [CNT_W-1:0]    sel_len;
    logic                accept;

    // Walk from the highest index down so the lowest eligible index is left selected.
    always_comb begin
        any_elig = 1'b0;
        sel_idx  = '0;
        sel_len  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (hazard_req[i] && (hazard_len[i*CNT_W +: CNT_W] != '0)) begin
                any_elig = 1'b1;
                sel_idx  = SRC_W'(i);
                sel_len  = hazard_len[i*CNT_W +: CNT_W];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && !flush && !reset && any_elig;

    // rem_q counts STALL-state cycles still to go including the current one,
    // so the cycles left after the current one is rem_q-1.
    always_comb begin
        stall           = 1'b0;
        stall_src       = '0;
        stall_remaining = '0;
        if (accept) begin
            stall           = 1'b1;
            stall_src       = sel_idx;
            stall_remaining = sel_len - CNT_W'(1);
        end else if ((state_q == S_STALL) && !flush) begin
            stall           = 1'b1;
            stall_src       = src_q;
            stall_remaining = rem_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        src_d   = src_q;
        if (flush) begin
            state_d = S_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        src_d   = sel_idx;
                        rem_d   = sel_len - CNT_W'(1);
                        state_d = (sel_len > CNT_W'(1)) ? S_STALL : S_RELEASE;
                    end
                end
                S_STALL: begin
                    if (rem_q <= CNT_W'(1)) begin
                        rem_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                S_RELEASE: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        event_cnt_d = event_cnt_q;
        if (stat_clear) begin
            stall_cnt_d = '0;
            event_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + STAT_W'(1);
            end
            if (accept && (event_cnt_q != '1)) begin
                event_cnt_d = event_cnt_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            src_q       <= '0;
            stall_cnt_q <= '0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            src_q       <= src_d;
            stall_cnt_q <= stall_cnt_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign stat_stall_cycles  = stall_cnt_q;
    assign stat_hazard_events = event_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (NUM_SRC=2, CNT_W=2, STAT_W=4).
// obs = {stall, stall_src, stall_remaining}; st = {stat_hazard_events, stat_stall_cycles}.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] hazard_req;
    logic [3:0] hazard_len;
    logic       flush;
    logic       stat_clear;
    logic       stall;
    logic [0:0] stall_src;
    logic [1:0] stall_remaining;
    logic [3:0] stat_stall_cycles;
    logic [3:0] stat_hazard_events;

    logic [3:0] obs;
    logic [7:0] st;
    int n_cmp;
    int n_err;

    assign obs = {stall, stall_src, stall_remaining};
    assign st  = {stat_hazard_events, stat_stall_cycles};

    hazard_stall_ctrl #(.NUM_SRC(2), .CNT_W(2), .STAT_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .hazard_req         (hazard_req),
        .hazard_len         (hazard_len),
        .flush              (flush),
        .stat_clear         (stat_clear),
        .stall              (stall),
        .stall_src          (stall_src),
        .stall_remaining    (stall_remaining),
        .stat_stall_cycles  (stat_stall_cycles),
        .stat_hazard_events (stat_hazard_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge and settle combinational outputs.
    task automatic cyc(input logic [1:0] req, input logic [1:0] l0, input logic [1:0] l1,
                       input logic fl, input logic clr);
        @(negedge clk);
        hazard_req = req;
        hazard_len = {l1, l0};
        flush      = fl;
        stat_clear = clr;
        #1;
    endtask

    task automatic idle_clear();
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b1);
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_obs got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL reset_stats got=%h exp=%h", st, 8'h00); end
        @(negedge clk);
        reset = 1'b0;
        hazard_req = 2'b00;
        #1;
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_after_obs got=%b exp=%b", obs, 4'b0000); end
    endtask

    task automatic test_single();
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL single_c1 got=%b exp=%b", obs, 4'b1010); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL single_c2 got=%b exp=%b", obs, 4'b1001); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL single_c3 got=%b exp=%b", obs, 4'b1000); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL single_release got=%b exp=%b", obs, 4'b0000); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL single_reaccept got=%b exp=%b", obs, 4'b1010); end
        n_cmp++; if (st !== 8'h13) begin n_err++; $display("FAIL single_stats5 got=%h exp=%h", st, 8'h13); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL single_c6 got=%b exp=%b", obs, 4'b1001); end
        n_cmp++; if (st !== 8'h24) begin n_err++; $display("FAIL single_events2 got=%h exp=%h", st, 8'h24); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL single_c7 got=%b exp=%b", obs, 4'b1000); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL single_c8 got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h26) begin n_err++; $display("FAIL single_stats8 got=%h exp=%h", st, 8'h26); end
    endtask

    task automatic test_priority();
        idle_clear();
        cyc(2'b11, 2'd1, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL prio_ch0 got=%b exp=%b", obs, 4'b1000); end
        cyc(2'b10, 2'd1, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL prio_release got=%b exp=%b", obs, 4'b0000); end
        cyc(2'b10, 2'd1, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1110) begin n_err++; $display("FAIL prio_ch1_c1 got=%b exp=%b", obs, 4'b1110); end
        cyc(2'b10, 2'd1, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1101) begin n_err++; $display("FAIL prio_ch1_c2 got=%b exp=%b", obs, 4'b1101); end
        cyc(2'b10, 2'd1, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL prio_ch1_c3 got=%b exp=%b", obs, 4'b1100); end
        cyc(2'b10, 2'd1, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL prio_mask got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h24) begin n_err++; $display("FAIL prio_stats got=%h exp=%h", st, 8'h24); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        idle_clear();
        cyc(2'b01, 2'd0, 2'd2, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL zero_c1 got=%b exp=%b", obs, 4'b0000); end
        cyc(2'b01, 2'd0, 2'd2, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL zero_c2 got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL zero_stats got=%h exp=%h", st, 8'h00); end
        cyc(2'b11, 2'd0, 2'd2, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1101) begin n_err++; $display("FAIL zero_skip_ch0 got=%b exp=%b", obs, 4'b1101); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1100) begin n_err++; $display("FAIL zero_ch1_c2 got=%b exp=%b", obs, 4'b1100); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL zero_release got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h12) begin n_err++; $display("FAIL zero_stats2 got=%h exp=%h", st, 8'h12); end
    endtask

    task automatic test_flush();
        idle_clear();
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL flush_accept got=%b exp=%b", obs, 4'b1010); end
        cyc(2'b00, 2'd0, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL flush_stall got=%b exp=%b", obs, 4'b0000); end
        cyc(2'b01, 2'd2, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL flush_idle_next got=%b exp=%b", obs, 4'b1001); end
        n_cmp++; if (st !== 8'h11) begin n_err++; $display("FAIL flush_stats1 got=%h exp=%h", st, 8'h11); end
        cyc(2'b01, 2'd2, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL flush_with_req got=%b exp=%b", obs, 4'b0000); end
        cyc(2'b10, 2'd0, 2'd3, 1'b1, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL flush_idle_req got=%b exp=%b", obs, 4'b0000); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL flush_no_accept got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h22) begin n_err++; $display("FAIL flush_stats2 got=%h exp=%h", st, 8'h22); end
    endtask

    task automatic test_max_saturation();
        logic [3:0] exp_ev;
        logic [3:0] exp_sc;
        idle_clear();
        for (int e = 0; e < 20; e++) begin
            exp_ev = (e > 15) ? 4'd15 : 4'(e);
            exp_sc = (3 * e > 15) ? 4'd15 : 4'(3 * e);
            cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
            n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL max_ep%0d_c1 got=%b exp=%b", e, obs, 4'b1010); end
            n_cmp++; if (st !== {exp_ev, exp_sc}) begin n_err++; $display("FAIL max_ep%0d_stats got=%h exp=%h", e, st, {exp_ev, exp_sc}); end
            cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
            n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL max_ep%0d_c2 got=%b exp=%b", e, obs, 4'b1001); end
            cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
            n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL max_ep%0d_c3 got=%b exp=%b", e, obs, 4'b1000); end
            cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
            n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL max_ep%0d_rel got=%b exp=%b", e, obs, 4'b0000); end
        end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (st !== 8'hFF) begin n_err++; $display("FAIL sat_stats got=%h exp=%h", st, 8'hFF); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b1);
        n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL clr_accept got=%b exp=%b", obs, 4'b1010); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL clr_wins got=%h exp=%h", st, 8'h00); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (st !== 8'h01) begin n_err++; $display("FAIL clr_resume got=%h exp=%h", st, 8'h01); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (st !== 8'h02) begin n_err++; $display("FAIL clr_resume2 got=%h exp=%h", st, 8'h02); end
    endtask

    task automatic test_async_reset();
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1010) begin n_err++; $display("FAIL areset_accept got=%b exp=%b", obs, 4'b1010); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL areset_stall got=%b exp=%b", obs, 4'b1001); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL areset_drop got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h00) begin n_err++; $display("FAIL areset_stats got=%h exp=%h", st, 8'h00); end
        cyc(2'b01, 2'd3, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset      = 1'b0;
        hazard_req = 2'b01;
        hazard_len = {2'd0, 2'd2};
        #1;
        n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL areset_new_accept got=%b exp=%b", obs, 4'b1001); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL areset_new_c2 got=%b exp=%b", obs, 4'b1000); end
        cyc(2'b00, 2'd0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL areset_new_rel got=%b exp=%b", obs, 4'b0000); end
        n_cmp++; if (st !== 8'h12) begin n_err++; $display("FAIL areset_new_stats got=%h exp=%h", st, 8'h12); end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        hazard_req = 2'b00;
        hazard_len = 4'h0;
        flush      = 1'b0;
        stat_clear = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_zero_len();
        test_flush();
        test_max_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
